fpga_top_fabric: RTL and testbench
==================================

Name: fpga_top_fabric

Overview:
- Behavioural model of the pre-configured FPGA fabric, personalised for the local_clk_test benchmark; it sits in place of the fabric netlist inside the formal-verification wrapper.
- Decodes the benchmark signals from fixed input pads and produces three registered AND results on fixed output pads: one on the global clock, one gated by a pad-derived local clock, one cleared by a pad-derived local reset.
- Keeps the configuration-chain and mode ports so that wrapper connectivity is unchanged.

Parameters:
- NUM_IN, 94, number of A2F input pads.
- NUM_OUT, 96, number of F2A output pads.
- NUM_CHAINS, 8, number of configuration chains.
- CHAIN_LEN, 16, bits per configuration chain.
- PAD_A, 50, input pad carrying A_i.
- PAD_B, 70, input pad carrying B_i.
- PAD_LCLK, 57, input pad carrying the local clock.
- PAD_LRSTN, 58, input pad carrying the active-low local reset.
- OUT_C, 50, output pad for C_o.
- OUT_CLK, 51, output pad for C_local_clk_o.
- OUT_RST, 52, output pad for C_local_rst_o.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- config_enable  in  1  shifts the configuration chains when high.
- SE0, SE1, SE2, SC0, SC1, SR  in  1 each  scan controls; tied off, no effect.
- gfpga_pad_pinput_extmode_A2F  in  [0:NUM_IN-1]  input pads.
- gfpga_pad_pinput_dchain_extmode_A2F  in  [0:1]  dchain pads; unused.
- gfpga_pad_poutput_F2A  out  [0:NUM_OUT-1]  output pads.
- gfpga_pad_pinput_extmode_mode_o  out  [0:NUM_IN-1]  per-pad mode.
- gfpga_pad_pinput_dchain_extmode_mode_o  out  [0:1]  constant 0.
- gfpga_pad_mmffosc2cko_wrapper_C_O  out  [0:11]  constant 0.
- ccff_head  in  [0:NUM_CHAINS-1]  serial configuration data in.
- ccff_tail  out  [0:NUM_CHAINS-1]  serial configuration data out.

Behaviour:
- Single clock domain on clk; all flops use synchronous, active-high reset.
- Definitions: a = A2F[PAD_A], b = A2F[PAD_B], ab = a & b.
- C register, on F2A[OUT_C]:
  - reset value 0;
  - every clk edge, C <= ab (latency 1).
- Local clock path:
  - A2F[PAD_LCLK] goes through a 2-flop synchroniser (sl1, sl2) and then a delay flop sl3;
  - lce = sl2 & ~sl3, a rising-edge strobe;
  - LC register, on F2A[OUT_CLK]: reset 0; when lce = 1, LC <= ab, otherwise hold;
  - the input samples ab in the cycle where lce = 1, so pad rise to output change is 3 clk cycles.
- Local reset path:
  - A2F[PAD_LRSTN] goes through a 2-flop synchroniser (sr1, sr2); all three flops reset to 0, i.e. local reset asserted;
  - LR register, on F2A[OUT_RST]: reset 0; if sr2 = 0, LR <= 0; else LR <= ab;
  - pad low to LR = 0 takes 3 cycles worst case.
- All other F2A bits: constant 0.
- extmode_mode_o: bit = 1 at PAD_A, PAD_B, PAD_LCLK and PAD_LRSTN; 0 elsewhere. Purely combinational constant.
- Configuration chains:
  - each chain is a CHAIN_LEN-bit shift register, reset to 0;
  - when config_enable = 1: bit0 <= ccff_head[i] and bit k <= bit k-1 on each clk;
  - when config_enable = 0: hold;
  - ccff_tail[i] = last bit;
  - chain contents do not alter the user logic (the fabric is pre-configured).
- Reset has priority over all updates, including a reset asserted mid-shift or mid-strobe; the synchronisers restart from 0.
- A held-high or static local-clock pad produces no further lce. A pad rise in the same cycle as reset deassertion is detected 2 cycles later.

Decomposition:
- Shared package fpga_top_pkg holds the pad index constants and NUM_IN/NUM_OUT/NUM_CHAINS.
- One natural sub-module, fpga_ccff_chain (single shift chain), instantiated NUM_CHAINS times.
- The synchronisers and user registers stay inline.

Test Plan:
- Reset: hold reset for 3 cycles with a=b=1 -> F2A[50..52] = 0, ccff_tail = 0, mode_o has exactly bits 50, 57, 58, 70 set.
- Global path: release reset, set a=1, b=1 -> F2A[50] = 1 after 1 cycle; set b=0 -> F2A[50] = 0 after 1 cycle.
- Local clock: a=b=1 with pad57 static 0 -> F2A[51] stays 0; pulse pad57 0->1 -> F2A[51] = 1 exactly 3 cycles later; then a=0 with pad57 held high -> F2A[51] stays 1 until the next rise.
- Local reset: pad58 = 0 with a=b=1 -> F2A[52] = 0; raise pad58 -> F2A[52] = 1 by cycle 3; drop pad58 -> F2A[52] = 0 within 3 cycles while F2A[50] stays 1.
- Config chain: config_enable = 1, shift pattern 1,0,1,1 into ccff_head[3] -> same pattern on ccff_tail[3] starting CHAIN_LEN cycles later; config_enable = 0 -> tail holds; C/LC/LR unaffected throughout.
- Scan/misc: toggle SE0..SR and the dchain pads -> no change on any output; mmffosc and dchain mode_o outputs remain 0.

Source files
------------

// File: rtl/fpga_top_pkg.sv
// ---------------------------------------------------------------------------
// fpga_top_pkg
// This package holds the shared constants for the behavioural fabric model
// used with the local_clk_test benchmark:
//   - the pad counts and configuration chain geometry;
//   - the input pad indices that carry the benchmark signals;
//   - the output pad indices that the three user registers drive.
// ---------------------------------------------------------------------------
package fpga_top_pkg;

  localparam int NUM_IN     = 94;
  localparam int NUM_OUT    = 96;
  localparam int NUM_CHAINS = 8;
  localparam int CHAIN_LEN  = 16;

  // A2F pads carrying the benchmark inputs
  localparam int PAD_A     = 50;
  localparam int PAD_B     = 70;
  localparam int PAD_LCLK  = 57;
  localparam int PAD_LRSTN = 58;

  // F2A pads driven by the user registers
  localparam int OUT_C   = 50;
  localparam int OUT_CLK = 51;
  localparam int OUT_RST = 52;

  // Width of the oscillator clock-out port kept for wrapper connectivity
  localparam int NUM_OSC_CO = 12;

endpackage

// File: rtl/fpga_ccff_chain.sv
// ---------------------------------------------------------------------------
// fpga_ccff_chain
// This module is one configuration chain: a CHAIN_LEN-bit serial shift
// register. The fabric is pre-configured, so nothing reads the chain
// contents. The chain exists only so that the serial path from head to tail
// behaves as the wrapper expects.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset; clears the chain
//   shift_en in   shifts one position per clock while high, holds otherwise
//   head     in   serial data in, which enters bit 0
//   tail     out  serial data out, taken from bit CHAIN_LEN-1
// ---------------------------------------------------------------------------
module fpga_ccff_chain #(
  parameter int CHAIN_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic head,
  output logic tail
);

  logic [CHAIN_LEN-1:0] bits_q;
  logic [CHAIN_LEN-1:0] bits_d;

  always_comb begin
    bits_d = bits_q;
    if (shift_en) begin
      bits_d = {bits_q[CHAIN_LEN-2:0], head};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign tail = bits_q[CHAIN_LEN-1];

endmodule

// File: rtl/fpga_top_fabric.sv
// ---------------------------------------------------------------------------
// fpga_top_fabric
// This module is a behavioural model of the pre-configured FPGA fabric for
// the local_clk_test benchmark. It takes the place of the fabric netlist
// inside the formal-verification wrapper.
//
// It drives three registered copies of (A & B) onto fixed output pads:
//   - C  : updates on every clk edge;
//   - LC : updates only on a synchronised rising edge of the local-clock pad;
//   - LR : is forced to 0 while the synchronised local reset (active low) is
//          asserted.
//
// The configuration chains, scan controls and mode outputs are kept so that
// the wrapper connections stay the same as with the real netlist.
//
// Ports:
//   clk, reset                           clock and sync active-high reset
//   config_enable                        shifts the configuration chains
//   SE0..SE2, SC0, SC1, SR               scan controls (no effect)
//   gfpga_pad_pinput_extmode_A2F         input pads
//   gfpga_pad_pinput_dchain_extmode_A2F  dchain pads (unused)
//   gfpga_pad_poutput_F2A                output pads
//   gfpga_pad_pinput_extmode_mode_o      per-pad mode (1 on used inputs)
//   gfpga_pad_pinput_dchain_extmode_mode_o, gfpga_pad_mmffosc2cko_wrapper_C_O
//                                        constant 0
//   ccff_head / ccff_tail                serial configuration data in/out
// ---------------------------------------------------------------------------
module fpga_top_fabric
  import fpga_top_pkg::*;
#(
  parameter int NUM_IN     = fpga_top_pkg::NUM_IN,
  parameter int NUM_OUT    = fpga_top_pkg::NUM_OUT,
  parameter int NUM_CHAINS = fpga_top_pkg::NUM_CHAINS,
  parameter int CHAIN_LEN  = fpga_top_pkg::CHAIN_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  config_enable,
  input  logic                  SE0,
  input  logic                  SE1,
  input  logic                  SE2,
  input  logic                  SC0,
  input  logic                  SC1,
  input  logic                  SR,
  input  logic [0:NUM_IN-1]     gfpga_pad_pinput_extmode_A2F,
  input  logic [0:1]            gfpga_pad_pinput_dchain_extmode_A2F,
  output logic [0:NUM_OUT-1]    gfpga_pad_poutput_F2A,
  output logic [0:NUM_IN-1]     gfpga_pad_pinput_extmode_mode_o,
  output logic [0:1]            gfpga_pad_pinput_dchain_extmode_mode_o,
  output logic [0:NUM_OSC_CO-1] gfpga_pad_mmffosc2cko_wrapper_C_O,
  input  logic [0:NUM_CHAINS-1] ccff_head,
  output logic [0:NUM_CHAINS-1] ccff_tail
);

  logic a;
  logic b;
  logic ab;
  logic lce;

  logic c_q,   c_d;
  logic lc_q,  lc_d;
  logic lr_q,  lr_d;
  logic sl1_q, sl1_d;
  logic sl2_q, sl2_d;
  logic sl3_q, sl3_d;
  logic sr1_q, sr1_d;
  logic sr2_q, sr2_d;

  assign a  = gfpga_pad_pinput_extmode_A2F[PAD_A];
  assign b  = gfpga_pad_pinput_extmode_A2F[PAD_B];
  assign ab = a & b;

  always_comb begin
    // Local clock: two synchroniser flops, then a delay flop. The pulse
    // detector lasts one cycle, on the first synchronised cycle after a rise.
    sl1_d = gfpga_pad_pinput_extmode_A2F[PAD_LCLK];
    sl2_d = sl1_q;
    sl3_d = sl2_q;
    lce   = sl2_q & ~sl3_q;

    // Local reset: both synchroniser flops reset to 0. This means the local
    // reset counts as asserted until the pad has been high for two cycles.
    sr1_d = gfpga_pad_pinput_extmode_A2F[PAD_LRSTN];
    sr2_d = sr1_q;

    c_d  = ab;
    lc_d = lce ? ab : lc_q;
    lr_d = sr2_q ? ab : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q   <= 1'b0;
      lc_q  <= 1'b0;
      lr_q  <= 1'b0;
      sl1_q <= 1'b0;
      sl2_q <= 1'b0;
      sl3_q <= 1'b0;
      sr1_q <= 1'b0;
      sr2_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      lc_q  <= lc_d;
      lr_q  <= lr_d;
      sl1_q <= sl1_d;
      sl2_q <= sl2_d;
      sl3_q <= sl3_d;
      sr1_q <= sr1_d;
      sr2_q <= sr2_d;
    end
  end

  always_comb begin
    gfpga_pad_poutput_F2A          = '0;
    gfpga_pad_poutput_F2A[OUT_C]   = c_q;
    gfpga_pad_poutput_F2A[OUT_CLK] = lc_q;
    gfpga_pad_poutput_F2A[OUT_RST] = lr_q;
  end

  always_comb begin
    gfpga_pad_pinput_extmode_mode_o            = '0;
    gfpga_pad_pinput_extmode_mode_o[PAD_A]     = 1'b1;
    gfpga_pad_pinput_extmode_mode_o[PAD_B]     = 1'b1;
    gfpga_pad_pinput_extmode_mode_o[PAD_LCLK]  = 1'b1;
    gfpga_pad_pinput_extmode_mode_o[PAD_LRSTN] = 1'b1;
  end

  assign gfpga_pad_pinput_dchain_extmode_mode_o = '0;
  assign gfpga_pad_mmffosc2cko_wrapper_C_O      = '0;

  for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
    fpga_ccff_chain #(
      .CHAIN_LEN (CHAIN_LEN)
    ) u_chain (
      .clk      (clk),
      .reset    (reset),
      .shift_en (config_enable),
      .head     (ccff_head[i]),
      .tail     (ccff_tail[i])
    );
  end

  // The scan controls, dchain pads and unused A2F pads are present only to
  // keep wrapper connectivity.
  logic unused_inputs;
  assign unused_inputs = ^{SE0, SE1, SE2, SC0, SC1, SR,
                           gfpga_pad_pinput_dchain_extmode_A2F,
                           gfpga_pad_pinput_extmode_A2F};

endmodule

// File: tb/tb_fpga_top_fabric.sv
module tb_fpga_top_fabric;
  localparam int NI = 94;
  localparam int NO = 96;
  localparam int NC = 8;
  localparam int CL = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          config_enable = 1'b0;
  logic          SE0 = 0, SE1 = 0, SE2 = 0, SC0 = 0, SC1 = 0, SR = 0;
  logic [0:NI-1] a2f = '0;
  logic [0:1]    dchain = '0;
  logic [0:NO-1] f2a;
  logic [0:NI-1] mode_o;
  logic [0:1]    dchain_mode;
  logic [0:11]   osc_co;
  logic [0:NC-1] head = '0;
  logic [0:NC-1] tail;

  fpga_top_fabric dut (
    .clk                                    (clk),
    .reset                                  (reset),
    .config_enable                          (config_enable),
    .SE0                                    (SE0),
    .SE1                                    (SE1),
    .SE2                                    (SE2),
    .SC0                                    (SC0),
    .SC1                                    (SC1),
    .SR                                     (SR),
    .gfpga_pad_pinput_extmode_A2F           (a2f),
    .gfpga_pad_pinput_dchain_extmode_A2F    (dchain),
    .gfpga_pad_poutput_F2A                  (f2a),
    .gfpga_pad_pinput_extmode_mode_o        (mode_o),
    .gfpga_pad_pinput_dchain_extmode_mode_o (dchain_mode),
    .gfpga_pad_mmffosc2cko_wrapper_C_O      (osc_co),
    .ccff_head                              (head),
    .ccff_tail                              (tail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-edge logs of the sampled inputs, plus the edge index
  // of the most recent reset. Outputs are derived from the rules in the spec.
  int             edge_n   = 0;
  int             last_rst = -1;
  bit             p57_log[$];
  bit             p58_log[$];
  bit             ab_log[$];
  logic [0:NC-1]  pushed[$];     // chain heads shifted in since last reset
  bit             exp_c, exp_lc, exp_lr;
  logic [0:NO-1]  exp_f2a;
  logic [0:NC-1]  exp_tail;
  logic [0:NI-1]  exp_mode;

  function automatic bit v57(int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return p57_log[k];
  endfunction

  function automatic bit v58(int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return p58_log[k];
  endfunction

  task automatic step();
    bit ab;
    @(posedge clk);
    ab = a2f[50] & a2f[70];
    p57_log.push_back(a2f[57]);
    p58_log.push_back(a2f[58]);
    ab_log.push_back(ab);
    if (reset) begin
      last_rst = edge_n;
      pushed.delete();
      exp_c = 0; exp_lc = 0; exp_lr = 0;
    end else begin
      exp_c = ab;
      // A rise between samples n-3 and n-2 captures ab at edge n
      if (v57(edge_n - 2) && !v57(edge_n - 3)) exp_lc = ab;
      exp_lr = v58(edge_n - 2) ? ab : 1'b0;
      if (config_enable) pushed.push_back(head);
    end
    exp_tail = (pushed.size() >= CL) ? pushed[pushed.size() - CL] : '0;
    exp_f2a = '0;
    exp_f2a[50] = exp_c;
    exp_f2a[51] = exp_lc;
    exp_f2a[52] = exp_lr;
    edge_n++;
    #1;
  endtask

  task automatic rand_a2f();
    for (int i = 0; i < NI; i++) a2f[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset = 1; a2f = '0; a2f[50] = 1; a2f[70] = 1; a2f[57] = 1; a2f[58] = 1;
    config_enable = 1; head = '1;
    repeat (3) step();
    n_checks++; if (f2a !== '0) begin n_fail++; $display("FAIL reset_f2a: got %h expected 0", f2a); end
    n_checks++; if (tail !== '0) begin n_fail++; $display("FAIL reset_tail: got %h expected 0", tail); end
    n_checks++; if (mode_o !== exp_mode) begin n_fail++; $display("FAIL reset_mode: got %h expected %h", mode_o, exp_mode); end
    n_checks++; if (dchain_mode !== 2'b00 || osc_co !== 12'h000) begin n_fail++; $display("FAIL reset_const: got %h/%h expected 0/0", dchain_mode, osc_co); end
    reset = 0; config_enable = 0; head = '0;
  endtask

  task automatic test_global();
    a2f = '0; a2f[50] = 1; a2f[70] = 1;
    step();
    n_checks++; if (f2a[50] !== 1'b1) begin n_fail++; $display("FAIL global_rise: got %b expected 1", f2a[50]); end
    a2f[70] = 0;
    step();
    n_checks++; if (f2a[50] !== 1'b0) begin n_fail++; $display("FAIL global_fall: got %b expected 0", f2a[50]); end
    n_checks++; if (f2a[51] !== 1'b0) begin n_fail++; $display("FAIL global_lc_idle: got %b expected 0", f2a[51]); end
    for (int i = 0; i < 30; i++) begin
      a2f[50] = 1'($urandom_range(0, 1)); a2f[70] = 1'($urandom_range(0, 1));
      step();
      n_checks++; if (f2a !== exp_f2a) begin n_fail++; $display("FAIL global_rand: got %h expected %h", f2a, exp_f2a); end
    end
  endtask

  task automatic test_local_clk();
    a2f = '0; a2f[50] = 1; a2f[70] = 1;
    repeat (6) step();
    n_checks++; if (f2a[51] !== 1'b0) begin n_fail++; $display("FAIL lclk_static: got %b expected 0", f2a[51]); end
    a2f[57] = 1;
    step(); step();
    n_checks++; if (f2a[51] !== 1'b0) begin n_fail++; $display("FAIL lclk_early: got %b expected 0", f2a[51]); end
    step();
    n_checks++; if (f2a[51] !== 1'b1) begin n_fail++; $display("FAIL lclk_3cyc: got %b expected 1", f2a[51]); end
    a2f[50] = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (f2a[51] !== 1'b1) begin n_fail++; $display("FAIL lclk_hold: got %b expected 1", f2a[51]); end
    end
    for (int i = 0; i < 150; i++) begin
      a2f[57] = 1'($urandom_range(0, 1));
      a2f[50] = 1'($urandom_range(0, 1)); a2f[70] = 1'($urandom_range(0, 1));
      step();
      n_checks++; if (f2a !== exp_f2a) begin n_fail++; $display("FAIL lclk_rand: got %h expected %h", f2a, exp_f2a); end
    end
  endtask

  task automatic test_local_rst();
    a2f = '0; a2f[50] = 1; a2f[70] = 1;
    repeat (4) step();
    n_checks++; if (f2a[52] !== 1'b0) begin n_fail++; $display("FAIL lrst_held: got %b expected 0", f2a[52]); end
    a2f[58] = 1;
    step(); step();
    n_checks++; if (f2a[52] !== 1'b0) begin n_fail++; $display("FAIL lrst_early: got %b expected 0", f2a[52]); end
    step();
    n_checks++; if (f2a[52] !== 1'b1) begin n_fail++; $display("FAIL lrst_release: got %b expected 1", f2a[52]); end
    a2f[58] = 0;
    repeat (3) step();
    n_checks++; if (f2a[52] !== 1'b0 || f2a[50] !== 1'b1) begin n_fail++; $display("FAIL lrst_assert: got LR=%b C=%b expected LR=0 C=1", f2a[52], f2a[50]); end
    for (int i = 0; i < 100; i++) begin
      a2f[58] = 1'($urandom_range(0, 3) != 0);
      a2f[50] = 1'($urandom_range(0, 1)); a2f[70] = 1'($urandom_range(0, 1));
      step();
      n_checks++; if (f2a !== exp_f2a) begin n_fail++; $display("FAIL lrst_rand: got %h expected %h", f2a, exp_f2a); end
    end
  endtask

  task automatic test_config();
    logic [3:0] pat;
    logic [3:0] seen;
    logic [0:NC-1] held;
    pat = 4'b1011;
    seen = '0;
    config_enable = 1;
    for (int i = 0; i < 40; i++) begin
      head = 8'($urandom);
      head[3] = (i < 4) ? pat[3 - i] : 1'b0;
      a2f[50] = 1'($urandom_range(0, 1)); a2f[70] = 1'($urandom_range(0, 1));
      a2f[57] = 1'($urandom_range(0, 1)); a2f[58] = 1'($urandom_range(0, 1));
      step();
      if (i >= CL - 1 && i < CL + 3) seen[CL + 2 - i] = tail[3];
      n_checks++; if (tail !== exp_tail) begin n_fail++; $display("FAIL cfg_shift: got %h expected %h", tail, exp_tail); end
      n_checks++; if (f2a !== exp_f2a) begin n_fail++; $display("FAIL cfg_user: got %h expected %h", f2a, exp_f2a); end
    end
    n_checks++; if (seen !== pat) begin n_fail++; $display("FAIL cfg_pattern: got %b expected %b", seen, pat); end
    config_enable = 0;
    held = exp_tail;
    for (int i = 0; i < 10; i++) begin
      head = 8'($urandom);
      step();
      n_checks++; if (tail !== held) begin n_fail++; $display("FAIL cfg_hold: got %h expected %h", tail, held); end
    end
  endtask

  task automatic test_scan_misc();
    for (int i = 0; i < 50; i++) begin
      {SE0, SE1, SE2, SC0, SC1, SR} = 6'($urandom);
      dchain = 2'($urandom);
      rand_a2f();
      head = 8'($urandom);
      step();
      n_checks++; if (f2a !== exp_f2a || tail !== exp_tail) begin n_fail++; $display("FAIL scan_out: got %h/%h expected %h/%h", f2a, tail, exp_f2a, exp_tail); end
      n_checks++; if (mode_o !== exp_mode || dchain_mode !== 2'b00 || osc_co !== 12'h000) begin n_fail++; $display("FAIL scan_const: got %h/%h/%h expected %h/0/0", mode_o, dchain_mode, osc_co, exp_mode); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 19) == 0);
      config_enable = 1'($urandom_range(0, 1));
      rand_a2f();
      head = 8'($urandom);
      step();
      n_checks++; if (f2a !== exp_f2a) begin n_fail++; $display("FAIL mid_f2a: got %h expected %h", f2a, exp_f2a); end
      n_checks++; if (tail !== exp_tail) begin n_fail++; $display("FAIL mid_tail: got %h expected %h", tail, exp_tail); end
    end
    reset = 0;
  endtask

  initial begin
    exp_mode = '0;
    exp_mode[50] = 1; exp_mode[57] = 1; exp_mode[58] = 1; exp_mode[70] = 1;
    test_reset();
    test_global();
    test_local_clk();
    test_local_rst();
    test_config();
    test_scan_misc();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
